// File: rtl/apb_arb_pkg.sv
// Shared widths and FSM state type for the APB request arbiter.
package apb_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping, and
// returns a one-hot winner (all zero when nobody requests).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win
);
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter feeding one APB master from NUM_REQ requesters.
// Optional BUSY timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      PCLK,
  input  logic                      PRESET_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_strb,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      write_read,
  output logic [ADDR_W-1:0]         addr_in,
  output logic [DATA_W-1:0]         wdata_in,
  output logic [STRB_W-1:0]         strb_in,
  input  logic                      transfer_done,
  input  logic                      error,
  input  logic [DATA_W-1:0]         rdata_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_done_q, rsp_done_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic               rsp_err_q, rsp_err_d, transfer_q, transfer_d;
  logic               write_read_q, write_read_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [STRB_W-1:0]  strb_q, strb_d;

  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   owner_idx;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_strb;
  logic               tmo_hit;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  // One-hot muxes: winner's command fields, and owner index for round-robin state.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_strb  = req_strb[i*STRB_W +: STRB_W];
      end
      if (gnt_q[i]) owner_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    rsp_done_d   = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    transfer_d   = transfer_q;
    write_read_d = write_read_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = BUSY;
          gnt_d        = win;
          transfer_d   = 1'b1;
          write_read_d = sel_write;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          strb_d       = sel_strb;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_d        = '0;
`endif
        end
      end
      BUSY: begin
        // A real completion wins over a timeout landing on the same cycle.
        if (transfer_done || tmo_hit) begin
          state_d     = IDLE;
          gnt_d       = '0;
          transfer_d  = 1'b0;
          rsp_done_d  = gnt_q;
          last_d      = owner_idx;
          rsp_err_d   = transfer_done ? error : 1'b1;
          rsp_rdata_d = (transfer_done && !write_read_q) ? rdata_out : '0;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      rsp_done_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      transfer_q   <= 1'b0;
      write_read_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      rsp_done_q   <= rsp_done_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      transfer_q   <= transfer_d;
      write_read_q <= write_read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign rsp_done   = rsp_done_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign transfer   = transfer_q;
  assign write_read = write_read_q;
  assign addr_in    = addr_q;
  assign wdata_in   = wdata_q;
  assign strb_in    = strb_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter; completions are checked against a queue
// of expected responses pushed when each transfer is finished by the bench.
module tb_apb_req_arbiter;
  localparam int N = 4;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET_n = 1'b0;
  logic [N-1:0]  req = '0, req_write = '0;
  logic [N*8-1:0]  req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_strb = '0;
  logic [N-1:0]  gnt, rsp_done;
  logic [31:0]   rsp_rdata, wdata_in;
  logic          rsp_err, transfer, write_read;
  logic [7:0]    addr_in;
  logic [3:0]    strb_in;
  logic          transfer_done = 1'b0, error = 1'b0;
  logic [31:0]   rdata_out = 32'hA5A5_5A5A;

  int ntests = 0;
  int nfails = 0;

  typedef struct packed {
    logic [3:0]  done;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .gnt(gnt), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .write_read(write_read), .addr_in(addr_in),
    .wdata_in(wdata_in), .strb_in(strb_in), .transfer_done(transfer_done),
    .error(error), .rdata_out(rdata_out)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every completion pulse must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (PRESET_n && rsp_done !== '0) begin
      if (exp_q.size() == 0) chk("unexpected_rsp_done", 64'(rsp_done), 64'(0));
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_done", 64'(rsp_done), 64'(mon_e.done));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i]        = wr;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]  = s;
  endtask

  task automatic wait_xfer(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      n++;
      if (transfer) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("transfer_start_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    PRESET_n = 1'b0;
    @(negedge PCLK);
    PRESET_n = 1'b1;
  endtask

  // Finishes a started transfer after nbusy transfer-high cycles.
  task automatic run_xfer(input int nbusy, input logic [31:0] rd, input logic er,
                          input logic [3:0] eg, input logic [7:0] ea, input logic ew,
                          input logic [31:0] ed, input logic [3:0] es,
                          input bit keep, input bit perturb, input int gap);
    bit ok;
    int n, hi;
    wait_xfer(ok, n);
    if (!ok) return;
    if (gap > 0) chk("idle_gap", 64'(n), 64'(gap));
    chk("gnt", 64'(gnt), 64'(eg));
    chk("addr_in", 64'(addr_in), 64'(ea));
    chk("write_read", 64'(write_read), 64'(ew));
    chk("wdata_in", 64'(wdata_in), 64'(ed));
    chk("strb_in", 64'(strb_in), 64'(es));
    hi = 1;
    for (int c = 1; c < nbusy; c++) begin
      if (perturb) begin
        req_addr[15:8] = 8'h08;
        req = '0;
      end
      @(negedge PCLK);
      if (transfer) hi++;
      if (perturb) chk("addr_stable", 64'(addr_in), 64'(ea));
    end
    exp_q.push_back('{eg, (ew ? 32'h0 : rd), er});
    rdata_out = rd;
    error = er;
    transfer_done = 1'b1;
    if (!keep) req = '0;
    @(negedge PCLK);
    transfer_done = 1'b0;
    error = 1'b0;
    rdata_out = 32'hA5A5_5A5A;
    chk("xfer_cycles", 64'(hi), 64'(nbusy));
    chk("transfer_low", 64'(transfer), 64'(0));
    chk("gnt_clear", 64'(gnt), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, hi;
    repeat (2) @(negedge PCLK);
    chk("reset_ctl", 64'({gnt, rsp_done, transfer, write_read, rsp_err}), 64'(0));
    chk("reset_cmd", 64'({addr_in, strb_in, wdata_in}), 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    PRESET_n = 1'b1;

    // Single write from requester 0; read data on the bus must not leak out.
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    req = 4'b0001;
    run_xfer(3, 32'hCAFEF00D, 1'b0, 4'b0001, 8'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 0, 0);

    // transfer_done while idle does nothing.
    transfer_done = 1'b1;
    repeat (2) @(negedge PCLK);
    transfer_done = 1'b0;
    chk("idle_done_transfer", 64'(transfer), 64'(0));
    chk("idle_done_rsp", 64'(rsp_done), 64'(0));

    // Round robin from reset with all requesters held.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 32'h0, 4'h0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      run_xfer(1, 32'h100 + 32'(i), 1'b0, 4'(1 << (i % 4)), 8'h40 + 8'(i % 4),
               1'b0, 32'h0, 4'h0, (i < 4), 0, (i > 0) ? 1 : 0);

    // Read with error from requester 2.
    set_req(2, 1'b0, 8'h20, 32'h0, 4'h0);
    req = 4'b0100;
    run_xfer(2, 32'h12345678, 1'b1, 4'b0100, 8'h20, 1'b0, 32'h0, 4'h0, 0, 0, 0);

    // Requester 1 changes its address and drops req mid-transfer.
    set_req(1, 1'b1, 8'h04, 32'h11112222, 4'h3);
    req = 4'b0010;
    run_xfer(4, 32'h0000BBBB, 1'b0, 4'b0010, 8'h04, 1'b1, 32'h11112222, 4'h3, 0, 1, 0);

    // Reset in the middle of a transfer.
    set_req(0, 1'b1, 8'h55, 32'h77778888, 4'h5);
    req = 4'b0001;
    wait_xfer(ok, n);
    chk("pre_reset_gnt", 64'(gnt), 64'(4'b0001));
    PRESET_n = 1'b0;
    #1;
    chk("async_reset_ctl", 64'({gnt, rsp_done, transfer, write_read, rsp_err}), 64'(0));
    chk("async_reset_cmd", 64'({addr_in, strb_in, wdata_in}), 64'(0));
    chk("async_reset_rdata", 64'(rsp_rdata), 64'(0));
    set_req(3, 1'b0, 8'h3C, 32'h0, 4'h0);
    req = 4'b1000;
    @(negedge PCLK);
    PRESET_n = 1'b1;
    run_xfer(2, 32'h0BADF00D, 1'b0, 4'b1000, 8'h3C, 1'b0, 32'h0, 4'h0, 0, 0, 0);

`ifdef APB_ARB_TIMEOUT_EN
    // No transfer_done: the arbiter must give up after TMO busy cycles.
    set_req(0, 1'b0, 8'h30, 32'h0, 4'h0);
    req = 4'b0001;
    wait_xfer(ok, n);
    exp_q.push_back('{4'b0001, 32'h0, 1'b1});
    req = '0;
    hi = 1;
    for (int c = 0; c < 3 * TMO; c++) begin
      @(negedge PCLK);
      if (!transfer) break;
      hi++;
    end
    chk("timeout_cycles", 64'(hi), 64'(TMO));
    chk("timeout_transfer_low", 64'(transfer), 64'(0));
`endif

    repeat (3) @(negedge PCLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, BUSY-cycle limit before abort.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: PCLK  in  1  rising-edge clock.
REQ-004 SHALL have PRESET_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have req  in  NUM_REQ  per-requester transfer request (level).
REQ-006 SHALL have req_write  in  NUM_REQ  per-requester direction (1 = write).
REQ-007 SHALL have req_addr  in  NUM_REQ*8  packed addresses; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have req_wdata  in  NUM_REQ*32  packed write data.
REQ-009 SHALL have req_strb  in  NUM_REQ*4  packed byte strobes.
REQ-010 SHALL have gnt  out  NUM_REQ  one-hot owner of the current transfer.
REQ-011 SHALL have rsp_done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 SHALL have rsp_rdata  out  32  read data, valid while any rsp_done bit is high.
REQ-013 SHALL have rsp_err  out  1  error flag, valid while any rsp_done bit is high.
REQ-014 SHALL have APB-master command outputs: transfer, write_read  out  1; addr_in  out  8; wdata_in  out  32; strb_in  out  4.
REQ-015 SHALL have APB-master status inputs: transfer_done  in  1; error  in  1; rdata_out  in  32.

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 IDLE, any req bit high at an edge: select winner by round-robin starting at index last+1 (wrapping at NUM_REQ-1 -> 0), latch its write/addr/wdata/strb, set gnt one-hot, enter BUSY.
REQ-018 BUSY: transfer=1 and command outputs driven from latched registers, stable for the whole transfer.
REQ-019 Latency: req sampled at edge k -> transfer and gnt high from edge k onward (registered outputs).
REQ-020 BUSY with transfer_done=1: register rdata_out/error into rsp_rdata/rsp_err, pulse rsp_done[owner] for exactly one cycle, set last=owner, clear gnt and transfer, return to IDLE.
REQ-021 Changes on req/req_* during BUSY SHALL be ignored; a dropped req does not abort the transfer.
REQ-022 At least one IDLE cycle separates consecutive transfers; transfer SHALL go low for at least one cycle.
REQ-023 A requester still asserting req after its rsp_done SHALL be treated as a new request and arbitrated normally.
REQ-024 rsp_rdata SHALL be forced to 0 on completion of a write.
REQ-025 transfer_done while in IDLE SHALL be ignored.

Reset
REQ-026 PRESET_n low SHALL asynchronously force state=IDLE, last=NUM_REQ-1 (index 0 wins first), and gnt, rsp_done, rsp_rdata, rsp_err, transfer, write_read, addr_in, wdata_in, strb_in, and timeout counter to 0.
REQ-027 Reset during BUSY SHALL abandon the transfer with no rsp_done pulse.

Configuration
REQ-028 Macro APB_ARB_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle; on reaching TIMEOUT_CYCLES without transfer_done, the arbiter SHALL pulse rsp_done[owner] with rsp_err=1 and rsp_rdata=0, drop transfer, and return to IDLE.
REQ-029 Macro not defined: no counter SHALL be present and BUSY SHALL wait indefinitely for transfer_done.

Structure
REQ-030 Package apb_arb_pkg SHALL hold ADDR_W=8, DATA_W=32, STRB_W=4 and the state enum typedef.
REQ-031 Winner selection SHALL be a combinational sub-module rr_arbiter (inputs req and last; output one-hot winner).

Verification
REQ-032 Single write: req=4'b0001, addr 8'h10, wdata 32'hDEADBEEF, strb 4'hF; transfer_done after 2 cycles -> addr_in=8'h10, transfer high for 3 cycles, rsp_done[0] pulses once, rsp_err=0.
REQ-033 Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0, with one IDLE cycle between transfers.
REQ-034 Read with error: requester 2 reads 8'h20; at done, rdata_out=32'h12345678 and error=1 -> rsp_rdata=32'h12345678, rsp_err=1, rsp_done=4'b0100.
REQ-035 Stability: requester 1 changes req_addr 8'h04->8'h08 mid-BUSY -> addr_in stays 8'h04 until done.
REQ-036 Reset mid-transfer: PRESET_n low during BUSY -> all outputs 0 immediately, no rsp_done; after release, req=4'b1000 wins.
REQ-037 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): transfer_done never asserted -> after 8 BUSY cycles rsp_done pulses, rsp_err=1, rsp_rdata=0, transfer low.
